// File: rtl/smart_mac_pkg.sv
// -----------------------------------------------------------------------------
// smart_mac_pkg
// Shared definitions for the smart multilane MAC processing element:
//   - state_e        : MAC FSM states
//   - CFG_* / cfg_*  : layout of the lane-routing configuration word
//   - sat_signed     : clamp a signed value to the range of a narrower width
// -----------------------------------------------------------------------------
package smart_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Configuration fields, LSB first. Each field is {sel, lane}.
    localparam int CFG_LEFT   = 0;
    localparam int CFG_TOP    = 1;
    localparam int CFG_RIGHT  = 2;
    localparam int CFG_BOTTOM = 3;
    localparam int CFG_FIELDS = 4;

    function automatic int cfg_field_w(input int lane_w);
        return lane_w + 1;
    endfunction

    // Lowest bit of a field; the lane index sits at [lsb +: lane_w].
    function automatic int cfg_field_lsb(input int field_idx, input int lane_w);
        return field_idx * (lane_w + 1);
    endfunction

    // The select bit is the top bit of each field.
    function automatic int cfg_sel_bit(input int field_idx, input int lane_w);
        return field_idx * (lane_w + 1) + lane_w;
    endfunction

    // Widest value the saturation helper accepts; callers sign-extend into it
    // and truncate the clamped result back to the target width.
    localparam int SAT_MAX_W = 128;

    function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
        input logic signed [SAT_MAX_W-1:0] val,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        max_v = (SAT_MAX_W'(1) <<< (width - 1)) - SAT_MAX_W'(1);
        min_v = ~max_v;
        if (val > max_v)
            return max_v;
        else if (val < min_v)
            return min_v;
        else
            return val;
    endfunction

endpackage

// File: rtl/smart_mac_multilane_bus_mux.sv
// -----------------------------------------------------------------------------
// smart_bus_lane_mux
// Lane extract and lane insert for one direction of the smart bus.
//   bus_in     : incoming bus, lane i at [i*WORD_SIZE +: WORD_SIZE]
//   ext_sel    : take ext_word from bus lane ext_lane instead of local_word
//   ext_lane   : lane to extract
//   local_word : operand used when ext_sel is low
//   ext_word   : selected operand
//   ins_sel    : replace bus lane ins_lane with ins_word
//   ins_lane   : lane to overwrite
//   ins_word   : word inserted onto the bus
//   bus_out    : outgoing bus; untouched lanes pass through combinationally
// -----------------------------------------------------------------------------
module smart_bus_lane_mux #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES*WORD_SIZE-1:0] bus_in,
    input  logic                           ext_sel,
    input  logic [LANE_W-1:0]              ext_lane,
    input  logic [WORD_SIZE-1:0]           local_word,
    output logic [WORD_SIZE-1:0]           ext_word,
    input  logic                           ins_sel,
    input  logic [LANE_W-1:0]              ins_lane,
    input  logic [WORD_SIZE-1:0]           ins_word,
    output logic [NUM_LANES*WORD_SIZE-1:0] bus_out
);

    // NOTE: assign a default before any conditional so no latch is inferred.
    always_comb begin
        ext_word = local_word;
        if (ext_sel) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ext_lane == LANE_W'(i))
                    ext_word = bus_in[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign bus_out[g*WORD_SIZE +: WORD_SIZE] =
            (ins_sel && ins_lane == LANE_W'(g)) ? ins_word
                                                : bus_in[g*WORD_SIZE +: WORD_SIZE];
    end

endmodule

// File: rtl/smart_mac_multilane.sv
// -----------------------------------------------------------------------------
// smart_mac_multilane
// Output-stationary MAC processing element with an N-lane smart bus in both
// directions. Operands may come from the local ports or a selected bus lane;
// forwarded operands may be inserted onto a selected bus lane.
//   clk, rst        : clock, asynchronous active-low reset
//   cfg_valid/data  : lane-routing configuration write (accepted in IDLE only)
//   cfg_ready       : high in IDLE
//   start, k_len    : begin accumulating k_len operand pairs
//   busy, done      : FSM not idle / one-cycle pulse with the result
//   in_valid        : operands valid this cycle
//   left_in, top_in : local west / north operands
//   right_out       : registered forwarded west operand
//   bottom_out      : registered forwarded north operand, or the result
//   fwd_valid       : right_out/bottom_out carry forwarded operands
//   result_valid    : bottom_out carries the result
//   hbus_*, vbus_*  : horizontal / vertical smart bus in and out
// -----------------------------------------------------------------------------
module smart_mac_multilane
    import smart_mac_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = $clog2(NUM_LANES),
    parameter int ACC_SIZE  = 2*WORD_SIZE + 4,
    parameter int FRAC_BITS = 0,
    parameter int CNT_W     = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [CFG_FIELDS*cfg_field_w(LANE_W)-1:0] cfg_data,
    input  logic                                      start,
    input  logic [CNT_W-1:0]                          k_len,
    output logic                                      busy,
    output logic                                      done,
    input  logic                                      in_valid,
    input  logic [WORD_SIZE-1:0]                      left_in,
    input  logic [WORD_SIZE-1:0]                      top_in,
    output logic [WORD_SIZE-1:0]                      right_out,
    output logic [WORD_SIZE-1:0]                      bottom_out,
    output logic                                      fwd_valid,
    output logic                                      result_valid,
    input  logic [NUM_LANES*WORD_SIZE-1:0]            hbus_in,
    input  logic [NUM_LANES*WORD_SIZE-1:0]            vbus_in,
    output logic [NUM_LANES*WORD_SIZE-1:0]            hbus_out,
    output logic [NUM_LANES*WORD_SIZE-1:0]            vbus_out
);

    localparam int CFG_W      = CFG_FIELDS * cfg_field_w(LANE_W);
    localparam int LEFT_LSB   = cfg_field_lsb(CFG_LEFT,   LANE_W);
    localparam int TOP_LSB    = cfg_field_lsb(CFG_TOP,    LANE_W);
    localparam int RIGHT_LSB  = cfg_field_lsb(CFG_RIGHT,  LANE_W);
    localparam int BOTTOM_LSB = cfg_field_lsb(CFG_BOTTOM, LANE_W);

    state_e                      state;
    logic [CFG_W-1:0]            cfg_q;
    logic signed [ACC_SIZE-1:0]  acc;
    logic [CNT_W-1:0]            cnt;

    logic signed [WORD_SIZE-1:0]   left_op;
    logic signed [WORD_SIZE-1:0]   top_op;
    logic signed [2*WORD_SIZE-1:0] product;
    logic signed [ACC_SIZE:0]      sum;
    logic signed [ACC_SIZE-1:0]    acc_next;
    logic signed [ACC_SIZE-1:0]    acc_shift;
    logic signed [WORD_SIZE-1:0]   result;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Horizontal bus: west operand extract, forwarded west operand insert.
    smart_bus_lane_mux #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_hbus_mux (
        .bus_in     (hbus_in),
        .ext_sel    (cfg_q[cfg_sel_bit(CFG_LEFT, LANE_W)]),
        .ext_lane   (cfg_q[LEFT_LSB +: LANE_W]),
        .local_word (left_in),
        .ext_word   (left_op),
        .ins_sel    (cfg_q[cfg_sel_bit(CFG_RIGHT, LANE_W)]),
        .ins_lane   (cfg_q[RIGHT_LSB +: LANE_W]),
        .ins_word   (right_out),
        .bus_out    (hbus_out)
    );

    // Vertical bus: north operand extract, bottom_out insert.
    smart_bus_lane_mux #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_vbus_mux (
        .bus_in     (vbus_in),
        .ext_sel    (cfg_q[cfg_sel_bit(CFG_TOP, LANE_W)]),
        .ext_lane   (cfg_q[TOP_LSB +: LANE_W]),
        .local_word (top_in),
        .ext_word   (top_op),
        .ins_sel    (cfg_q[cfg_sel_bit(CFG_BOTTOM, LANE_W)]),
        .ins_lane   (cfg_q[BOTTOM_LSB +: LANE_W]),
        .ins_word   (bottom_out),
        .bus_out    (vbus_out)
    );

    // One extra bit on the sum so the clamp sees the true value, not a wrap.
    assign product   = left_op * top_op;
    assign sum       = (ACC_SIZE+1)'(acc) + (ACC_SIZE+1)'(product);
    assign acc_next  = ACC_SIZE'(sat_signed(SAT_MAX_W'(sum), ACC_SIZE));
    assign acc_shift = acc_next >>> FRAC_BITS;
    assign result    = WORD_SIZE'(sat_signed(SAT_MAX_W'(acc_shift), WORD_SIZE));

    // NOTE: non-blocking assignments so every register reads pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cfg_q        <= '0;
            acc          <= '0;
            cnt          <= '0;
            right_out    <= '0;
            bottom_out   <= '0;
            fwd_valid    <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            // cfg_ready gates the write, so cfg is frozen while busy.
            if (cfg_valid && cfg_ready)
                cfg_q <= cfg_data;

            case (state)
                IDLE: begin
                    fwd_valid <= 1'b0;
                    if (start) begin
                        if (k_len == '0) begin
                            state        <= DRAIN;
                            bottom_out   <= '0;
                            result_valid <= 1'b1;
                            done         <= 1'b1;
                        end else begin
                            state <= ACCUM;
                            acc   <= '0;
                            cnt   <= k_len;
                        end
                    end
                end

                ACCUM: begin
                    if (in_valid) begin
                        acc       <= acc_next;
                        cnt       <= cnt - CNT_W'(1);
                        right_out <= left_op;
                        if (cnt == CNT_W'(1)) begin
                            // Last pair: bottom_out carries the result instead
                            // of the forwarded north operand.
                            state        <= DRAIN;
                            bottom_out   <= result;
                            fwd_valid    <= 1'b0;
                            result_valid <= 1'b1;
                            done         <= 1'b1;
                        end else begin
                            bottom_out <= top_op;
                            fwd_valid  <= 1'b1;
                        end
                    end else begin
                        fwd_valid <= 1'b0;
                    end
                end

                DRAIN: begin
                    state        <= IDLE;
                    fwd_valid    <= 1'b0;
                    result_valid <= 1'b0;
                    done         <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/smart_mac_multilane.md
Name: smart_mac_multilane

Overview:
Next-generation smart MAC processing element for the systolic array, with an N-lane smart bus in both directions.
- Any operand input can be sourced from, and any forwarded output inserted onto, a selectable bus lane; a configuration word sets the lane routing.
- Contains an output-stationary MAC FSM: accumulates K operand pairs with saturation, then drains a scaled, saturated result on bottom_out.
- Instantiated per array cell by the array generator.

Parameters:
WORD_SIZE, 16, operand/output word width (signed)
NUM_LANES, 4, smart bus lanes per direction
LANE_W, $clog2(NUM_LANES), lane index width (derived)
ACC_SIZE, 2*WORD_SIZE+4, signed accumulator width
FRAC_BITS, 0, arithmetic right shift applied to the accumulator before output saturation
CNT_W, 8, width of k_len

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is asynchronous and active-low
cfg_valid  in  1  configuration write strobe
cfg_ready  out  1  high only in IDLE
cfg_data  in  4*(1+LANE_W)  fields, LSB first: {left_sel,left_lane},{top_sel,top_lane},{right_sel,right_lane},{bottom_sel,bottom_lane}
start  in  1  begin an accumulation
k_len  in  CNT_W  number of valid operand pairs to accumulate
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in DRAIN
in_valid  in  1  operands valid this cycle
left_in  in  WORD_SIZE  west operand
top_in  in  WORD_SIZE  north operand
right_out  out  WORD_SIZE  registered forwarded west operand
bottom_out  out  WORD_SIZE  registered forwarded north operand, or result in DRAIN
fwd_valid  out  1  right_out/bottom_out carry forwarded operands
result_valid  out  1  bottom_out carries the result
hbus_in  in  NUM_LANES*WORD_SIZE  horizontal smart bus in (lane i at bits [i*W +: W])
vbus_in  in  NUM_LANES*WORD_SIZE  vertical smart bus in
hbus_out  out  NUM_LANES*WORD_SIZE  horizontal smart bus out
vbus_out  out  NUM_LANES*WORD_SIZE  vertical smart bus out

Behaviour:
- Reset: state IDLE; cfg register, accumulator, counter, right_out, bottom_out, fwd_valid, result_valid and done all 0. Zero cfg gives a plain systolic PE.
- Operand select (combinational): left_op = left_sel ? hbus_in[left_lane] : left_in. top_op is formed the same way from vbus_in.
- Bus insert (combinational): hbus_out lane i = (right_sel && right_lane==i) ? right_out : hbus_in lane i. vbus_out is formed the same way with bottom_sel/bottom_lane and bottom_out. Non-selected lanes pass through with zero latency.
- Config: cfg latched when cfg_valid && cfg_ready. It is ignored while busy; the cfg register is unchanged.
- FSM IDLE:
  - start with k_len>0 -> ACCUM; acc<=0; cnt<=k_len.
  - start with k_len==0 -> DRAIN; result 0.
  - cfg_valid and start in the same cycle: cfg is latched and the accumulation uses the new cfg.
- FSM ACCUM:
  - Each in_valid cycle: acc <= sat_ACC(acc + left_op*top_op), where the product is signed 2*WORD_SIZE and sign-extended. Also right_out<=left_op, bottom_out<=top_op, fwd_valid<=1, cnt--.
  - Cycles without in_valid are bubbles: acc, cnt and the output registers hold; fwd_valid<=0.
  - in_valid with cnt==1 -> DRAIN, and bottom_out <= sat_WORD(acc_next >>> FRAC_BITS).
- FSM DRAIN (exactly one cycle): result_valid=1, done=1, fwd_valid=0; -> IDLE. In this cycle right_out still shows the last forwarded operand.
- Latency: forwarding is 1 cycle after the operand. The result appears 1 cycle after the last valid operand.
- start is ignored while busy. in_valid in IDLE/DRAIN is ignored: no forward, no accumulate.
- Saturation: clamp to the signed min/max of the target width, never wrap. Shift is arithmetic, truncating toward -inf.
- Asserting rst mid-operation returns everything to reset values immediately; no done is emitted.

Decomposition:
- Package smart_mac_pkg:
  - FSM state enum (IDLE, ACCUM, DRAIN)
  - cfg field offset/width constants as functions of LANE_W
  - signed saturation function parametrised by width
- Sub-module smart_bus_lane_mux (WORD_SIZE, NUM_LANES): lane extract and lane insert/pass-through. Instantiated once per bus direction for extract and once for insert.

Test Plan:
- Zero cfg, k_len=3, pairs (2,3),(4,5),(-1,7) -> right_out 2,4,-1 on successive cycles; bottom_out=19 with result_valid and done high for one cycle; busy low afterwards.
- cfg top_sel=1 lane 2, right_sel=1 lane 1; vbus lane2=0x0010, top_in=0x0003, left_in=2, k_len=1 -> result 0x0020; hbus_out lane1 equals right_out (2); hbus lanes 0,2,3 equal hbus_in.
- k_len=4 of 0x7FFF*0x7FFF -> bottom_out 0x7FFF; 0x8000*0x7FFF x4 -> 0x8000; FRAC_BITS=4 build, 16*16 -> 0x0010.
- k_len=2 with bubbles (in_valid 1,0,0,1) -> busy for 5 cycles; fwd_valid only on the valid cycles; correct sum.
- k_len=0 -> result_valid with bottom_out=0 in the next cycle. cfg_valid during ACCUM -> cfg unchanged. cfg+start in the same cycle -> new lanes used.
- rst low mid-ACCUM -> all outputs 0 asynchronously, state IDLE; new start after release -> correct result with no residue from the aborted run.
